// File: rtl/itof_seq_normalizer_if.sv
// Operand/result handshake bundle for itof_seq_normalizer.
// The master side presents operands and consumes results.
// The slave side is the normalizer itself.
interface itof_seq_normalizer_if;
  logic        in_valid;
  logic        in_ready;
  logic        is_unsigned;
  logic [1:0]  rounding_mode;
  logic [31:0] i;
  logic        out_valid;
  logic        out_ready;
  logic        is_zero;
  logic [8:0]  sign_and_exp;
  logic [31:0] mantissa_candidate;
  logic [1:0]  rounding_mode_q;

  modport master (
    output in_valid, is_unsigned, rounding_mode, i, out_ready,
    input  in_ready, out_valid, is_zero, sign_and_exp, mantissa_candidate, rounding_mode_q
  );

  modport slave (
    input  in_valid, is_unsigned, rounding_mode, i, out_ready,
    output in_ready, out_valid, is_zero, sign_and_exp, mantissa_candidate, rounding_mode_q
  );
endinterface

// File: rtl/itof_seq_normalizer.sv
// Iterative integer-to-float normalizer feeding the FP rounding stage.
// The block takes one operand at a time. It finds sign and magnitude,
// then shifts the magnitude left until the leading one sits at bit 31.
// It presents {sign, biased exp} and the left-justified mantissa.
// Optional macro ITOF_COARSE_SHIFT_EN: enables 8-bit shift steps while
// the top byte of the magnitude is zero. This cuts worst-case latency
// from 33 to 12 cycles. Results are identical either way.
module itof_seq_normalizer #(
  parameter int BIAS = 127
) (
  input  logic                   clk,
  input  logic                   rst,
  itof_seq_normalizer_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_DONE} state_t;

  state_t      r_state, w_state_nxt;

  // working registers for the operand in flight
  logic [31:0] r_mant, w_mant_nxt;
  logic [5:0]  r_cnt,  w_cnt_nxt;
  logic        r_sign, w_sign_nxt;
  logic [1:0]  r_rm,   w_rm_nxt;

  // registered outputs; they change only when a result is produced
  logic        r_out_valid, w_out_valid_nxt;
  logic        r_is_zero,   w_is_zero_nxt;
  logic [8:0]  r_sexp,      w_sexp_nxt;
  logic [31:0] r_mcand,     w_mcand_nxt;
  logic [1:0]  r_rm_q,      w_rm_q_nxt;

  logic        w_in_sign;
  logic [31:0] w_in_mag;
  logic [7:0]  w_exp;

  // Signed 0x80000000 negates to itself, which is the correct magnitude.
  assign w_in_sign = ~bus.is_unsigned & bus.i[31];
  assign w_in_mag  = w_in_sign ? (32'd0 - bus.i) : bus.i;

  // Shift count never exceeds 31, so the exponent stays in 127..158.
  assign w_exp = 8'(BIAS + 31 - int'(r_cnt));

  assign bus.in_ready           = (r_state == S_IDLE) & ~rst;
  assign bus.out_valid          = r_out_valid;
  assign bus.is_zero            = r_is_zero;
  assign bus.sign_and_exp       = r_sexp;
  assign bus.mantissa_candidate = r_mcand;
  assign bus.rounding_mode_q    = r_rm_q;

  // Next state, working-register updates and result capture.
  always_comb begin
    w_state_nxt     = r_state;
    w_mant_nxt      = r_mant;
    w_cnt_nxt       = r_cnt;
    w_sign_nxt      = r_sign;
    w_rm_nxt        = r_rm;
    w_out_valid_nxt = r_out_valid;
    w_is_zero_nxt   = r_is_zero;
    w_sexp_nxt      = r_sexp;
    w_mcand_nxt     = r_mcand;
    w_rm_q_nxt      = r_rm_q;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_sign_nxt = w_in_sign;
          w_mant_nxt = w_in_mag;
          w_cnt_nxt  = 6'd0;
          w_rm_nxt   = bus.rounding_mode;
          if (w_in_mag == 32'd0) begin
            // Zero skips normalization; sign is forced to 0.
            w_state_nxt     = S_DONE;
            w_out_valid_nxt = 1'b1;
            w_is_zero_nxt   = 1'b1;
            w_sexp_nxt      = 9'd0;
            w_mcand_nxt     = 32'd0;
            w_rm_q_nxt      = bus.rounding_mode;
          end else begin
            w_state_nxt = S_NORM;
          end
        end
      end
      S_NORM: begin
        if (r_mant[31]) begin
          w_state_nxt     = S_DONE;
          w_out_valid_nxt = 1'b1;
          w_is_zero_nxt   = 1'b0;
          w_sexp_nxt      = {r_sign, w_exp};
          w_mcand_nxt     = r_mant;
          w_rm_q_nxt      = r_rm;
`ifdef ITOF_COARSE_SHIFT_EN
        end else if (r_mant[31:24] == 8'd0) begin
          w_mant_nxt = {r_mant[23:0], 8'd0};
          w_cnt_nxt  = r_cnt + 6'd8;
`endif
        end else begin
          w_mant_nxt = {r_mant[30:0], 1'b0};
          w_cnt_nxt  = r_cnt + 6'd1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_state_nxt     = S_IDLE;
          w_out_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Working registers for sign, magnitude, shift count and rounding mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mant <= 32'd0;
      r_cnt  <= 6'd0;
      r_sign <= 1'b0;
      r_rm   <= 2'd0;
    end else begin
      r_mant <= w_mant_nxt;
      r_cnt  <= w_cnt_nxt;
      r_sign <= w_sign_nxt;
      r_rm   <= w_rm_nxt;
    end
  end

  // Result registers; they hold steady while the downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_is_zero   <= 1'b0;
      r_sexp      <= 9'd0;
      r_mcand     <= 32'd0;
      r_rm_q      <= 2'd0;
    end else begin
      r_out_valid <= w_out_valid_nxt;
      r_is_zero   <= w_is_zero_nxt;
      r_sexp      <= w_sexp_nxt;
      r_mcand     <= w_mcand_nxt;
      r_rm_q      <= w_rm_q_nxt;
    end
  end

endmodule

// File: tb/tb_itof_seq_normalizer.sv
// Self-checking bench for itof_seq_normalizer.
// It runs directed and random operands against a behavioural reference.
// It also covers stall, reset abort and back-to-back turnaround.
module tb_itof_seq_normalizer;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  itof_seq_normalizer_if bus();

  itof_seq_normalizer #(.BIAS(127)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: find the leading one with plain arithmetic.
  // Latency is 2 cycles plus the number of shift steps (1 for zero).
  function automatic void model(input logic uns, input logic [31:0] v,
                                output logic z, output logic [8:0] se,
                                output logic [31:0] m, output int lat);
    logic        s;
    logic [31:0] mag;
    int          p;
    int          sh;
    s   = !uns && v[31];
    mag = s ? (32'd0 - v) : v;
    if (mag == 32'd0) begin
      z = 1'b1; se = 9'd0; m = 32'd0; lat = 1;
    end else begin
      p = 31;
      while (mag[p] == 1'b0) p--;
      sh = 31 - p;
      z  = 1'b0;
      se = {s, 8'(127 + p)};
      m  = mag << sh;
`ifdef ITOF_COARSE_SHIFT_EN
      lat = 2 + sh / 8 + sh % 8;
`else
      lat = 2 + sh;
`endif
    end
  endfunction

  // Presents one operand, then waits (bounded) for out_valid.
  // It returns the observed latency (-1 on timeout) and outputs.
  task automatic run_op(input logic uns, input logic [1:0] rm, input logic [31:0] v,
                        output int lat, output logic z, output logic [8:0] se,
                        output logic [31:0] m, output logic [1:0] rq);
    @(posedge clk); #1;
    bus.is_unsigned = uns; bus.rounding_mode = rm; bus.i = v; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.i = $urandom; bus.rounding_mode = ~rm; bus.is_unsigned = ~uns;
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) lat = -1;
    z = bus.is_zero; se = bus.sign_and_exp; m = bus.mantissa_candidate; rq = bus.rounding_mode_q;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.is_zero !== 1'b0 ||
        bus.sign_and_exp !== 9'd0 || bus.mantissa_candidate !== 32'd0 || bus.rounding_mode_q !== 2'd0)
      $display("FAIL reset_values: rdy=%b vld=%b z=%b se=%h m=%h rq=%b, required 0 0 0 000 00000000 00",
               bus.in_ready, bus.out_valid, bus.is_zero, bus.sign_and_exp, bus.mantissa_candidate, bus.rounding_mode_q);
    else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL reset_release: rdy=%b vld=%b, required 1 0", bus.in_ready, bus.out_valid);
    else n_pass++;
  endtask

  // Runs a list of operands with out_ready high and checks every field,
  // then checks the transfer and in_ready on the next cycle.
  task automatic test_ops(input string tag, input int n, input bit rnd);
    logic [31:0] dv[8]  = '{32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h0,
                            32'h0, 32'h00012345, 32'h1, 32'h7FFFFFFF};
    logic        du[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0]  dr[8]  = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b00, 2'b11};
    logic [31:0] v;
    logic        u, z, ez;
    logic [1:0]  rm, rq;
    logic [8:0]  se, ese;
    logic [31:0] m, em;
    int          lat, elat;
    bus.out_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (rnd) begin
        v  = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
        u  = 1'($urandom);
        rm = 2'($urandom);
      end else begin
        v = dv[k]; u = du[k]; rm = dr[k];
      end
      model(u, v, ez, ese, em, elat);
      run_op(u, rm, v, lat, z, se, m, rq);
      n_total++;
      if (lat !== elat || z !== ez || se !== ese || m !== em || rq !== rm)
        $display("FAIL %s[%0d] u=%b i=%h: lat=%0d z=%b se=%h m=%h rq=%b, required lat=%0d z=%b se=%h m=%h rq=%b",
                 tag, k, u, v, lat, z, se, m, rq, elat, ez, ese, em, rm);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
        $display("FAIL %s_turnaround[%0d]: vld=%b rdy=%b, required 0 1", tag, k, bus.out_valid, bus.in_ready);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic        z, ez;
    logic [1:0]  rq;
    logic [8:0]  se, ese;
    logic [31:0] m, em;
    int          lat, elat;
    model(1'b1, 32'h00012345, ez, ese, em, elat);
    bus.out_ready = 1'b0;
    run_op(1'b1, 2'b10, 32'h00012345, lat, z, se, m, rq);
    n_total++;
    if (lat !== elat || se !== 9'h08F || m !== 32'h91A28000)
      $display("FAIL stall_result: lat=%0d se=%h m=%h, required lat=%0d se=08f m=91a28000", lat, se, m, elat);
    else n_pass++;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_total++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.sign_and_exp !== ese ||
          bus.mantissa_candidate !== em || bus.is_zero !== ez || bus.rounding_mode_q !== 2'b10)
        $display("FAIL stall_hold[%0d]: vld=%b rdy=%b se=%h m=%h, required 1 0 %h %h",
                 c, bus.out_valid, bus.in_ready, bus.sign_and_exp, bus.mantissa_candidate, ese, em);
      else n_pass++;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL stall_release: vld=%b rdy=%b, required 0 1", bus.out_valid, bus.in_ready);
    else n_pass++;
  endtask

  task automatic test_reset_mid_norm();
    logic        z;
    logic [1:0]  rq;
    logic [8:0]  se;
    logic [31:0] m;
    int          lat, seen;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.is_unsigned = 1'b1; bus.rounding_mode = 2'b11; bus.i = 32'h1; bus.in_valid = 1'b1;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.in_ready !== 1'b0)
      $display("FAIL rst_ready_low: rdy=%b, required 0", bus.in_ready);
    else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.sign_and_exp !== 9'd0 ||
        bus.mantissa_candidate !== 32'd0 || bus.rounding_mode_q !== 2'd0)
      $display("FAIL rst_abort_state: vld=%b rdy=%b se=%h m=%h rq=%b, required 0 1 000 00000000 00",
               bus.out_valid, bus.in_ready, bus.sign_and_exp, bus.mantissa_candidate, bus.rounding_mode_q);
    else n_pass++;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    n_total++;
    if (seen !== 0)
      $display("FAIL rst_discard: out_valid seen %0d cycles, required 0", seen);
    else n_pass++;
    run_op(1'b0, 2'b01, 32'hFFFFFFFF, lat, z, se, m, rq);
    n_total++;
    if (se !== 9'h17F || m !== 32'h80000000 || z !== 1'b0 || rq !== 2'b01)
      $display("FAIL rst_next_op: se=%h m=%h z=%b rq=%b, required 17f 80000000 0 01", se, m, z, rq);
    else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.is_unsigned = 1'b0; bus.rounding_mode = 2'b00;
    bus.i = 32'd0; bus.out_ready = 1'b1;
    test_reset();
    test_ops("directed", 8, 1'b0);
    test_backpressure();
    test_reset_mid_norm();
    test_ops("random", 40, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/itof_seq_normalizer.md
# itof_seq_normalizer

Iterative, handshaked integer-to-float normalizer. It sits directly upstream of the FP rounding stage. It accepts a 32-bit integer with its signedness and rounding mode, then computes sign, magnitude and leading-one position over several cycles. It presents `is_zero`, `sign_and_exp` and a left-justified `mantissa_candidate` for the rounding stage to consume. It replaces a single-cycle 32-bit priority encoder and barrel shifter with a small shift FSM, trading latency for area and timing slack.

## Interface
Parameters:
- `BIAS`, 127: exponent bias added to the leading-one position.

Ports:
- `clk`  in  1  clock. There is one clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  operand valid.
- `in_ready`  out  1  block can accept an operand.
- `is_unsigned`  in  1  1 = treat `i` as unsigned, 0 = two's complement.
- `rounding_mode`  in  2  rounding mode; captured on accept and carried through.
- `i`  in  32  integer operand.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream consumes the result.
- `is_zero`  out  1  operand was zero.
- `sign_and_exp`  out  9  {sign, biased exponent[7:0]}.
- `mantissa_candidate`  out  32  normalized magnitude, with the leading one at bit 31 (0 if zero).
- `rounding_mode_q`  out  2  captured rounding mode.

## Operation
- The FSM has three states:
  - IDLE: `in_ready` = 1. On `in_valid`, the block captures `rounding_mode`, sign = `~is_unsigned & i[31]`, and magnitude = `sign ? -i : i` (32-bit; signed 0x80000000 gives magnitude 0x80000000). Shift count clears to 0. Next state is DONE if magnitude == 0, otherwise NORM.
  - NORM: each cycle takes exactly one of these actions:
    - if mant[31] = 1, go to DONE;
    - else if coarse shift is enabled and mant[31:24] == 0, shift mant left 8 and add 8 to count;
    - else shift mant left 1 and add 1 to count.
  - DONE: `out_valid` = 1. On `out_ready`, go to IDLE.
- Output rules:
  - Exponent = BIAS + 31 − count. This lies in 127..158 and needs no overflow handling.
  - Zero result: `is_zero` = 1, `sign_and_exp` = 0, `mantissa_candidate` = 0. Sign is forced to 0.
  - `in_ready` is 0 in NORM and DONE. There is no overlap between consecutive operands.
  - Outputs are registered and held stable while `out_valid` & !`out_ready`.

## Timing
- Reset values: state IDLE, `out_valid` = 0, `is_zero` = 0, `sign_and_exp` = 0, `mantissa_candidate` = 0, `rounding_mode_q` = 0. `in_ready` is forced to 0 while `rst` is high.
- Taking the accept edge as cycle T:
  - zero operand: `out_valid` at T+1;
  - operand with bit 31 of the magnitude set: T+2;
  - general case: T+2+shift steps.
- Worst case with coarse shift is magnitude 1: 3 coarse steps + 7 fine steps, so `out_valid` at T+12. Worst case without coarse shift is `out_valid` at T+33.
- Handshake: a transfer occurs on a cycle where valid & ready are both high. `out_valid` never drops without a transfer, except on reset.
- Reset asserted mid-NORM or mid-DONE aborts the operation. The next cycle is IDLE with outputs at reset values, and the in-flight result is discarded.
- Back-to-back operation: after the output transfer at cycle U, `in_ready` is 1 at U+1.

## Configuration
- `ITOF_COARSE_SHIFT_EN`:
  - Defined: NORM takes 8-bit steps while mant[31:24] == 0. Worst-case latency is 12 cycles.
  - Undefined: only 1-bit steps are taken. Worst-case latency is 33 cycles.
- Results are bit-identical in both configurations; only latency differs.

## Test plan
- Signed `i` = 0xFFFFFFFF, mode 2'b01, `out_ready` = 1 → at T+12: `sign_and_exp` = 9'h17F, `mantissa_candidate` = 0x80000000, `is_zero` = 0, `rounding_mode_q` = 2'b01.
- Unsigned 0x80000000 → at T+2: `sign_and_exp` = 9'h09E, mant 0x80000000. Signed 0x80000000 → 9'h19E, mant 0x80000000.
- `i` = 0 (signed and unsigned) → at T+1: `is_zero` = 1, `sign_and_exp` = 0, mant 0.
- Unsigned 0x00012345 → 1 coarse + 7 fine steps, at T+10: `sign_and_exp` = 9'h08F, mant 0x91A28000. Without the macro, the same values appear at T+17.
- Hold `out_ready` low for 5 cycles after `out_valid` → outputs are stable and `in_ready` = 0. On release, the transfer completes and `in_ready` = 1 on the next cycle.
- Assert `rst` for 1 cycle during NORM of operand 1 → `out_valid` never rises for it. A following operand 0xFFFFFFFF yields 9'h17F.
